// File: rtl/avst_rx_monitor.sv
// Passive Avalon-ST sink/checker: tracks SOP/EOP framing, counts good packets,
// bytes and framing errors, and registers per-packet length and XOR checksum.
module avst_rx_monitor #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned EMPTY_W   = 2,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MAX_BEATS = 512
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [EMPTY_W-1:0] in_empty,
  input  logic               in_valid,
  input  logic               clear,
  output logic               pkt_done,
  output logic [15:0]        last_len,
  output logic [DATA_W-1:0]  last_csum,
  output logic [CNT_W-1:0]   pkt_count,
  output logic [CNT_W-1:0]   byte_count,
  output logic [CNT_W-1:0]   err_count,
  output logic [2:0]         err_flags
);

  localparam int unsigned BYTES   = DATA_W / 8;
  localparam int unsigned BEAT_W  = $clog2(MAX_BEATS + 2);
  localparam int unsigned BYTES_W = $clog2(BYTES) + 1;
  localparam int unsigned LEN_W   = (BEAT_W + BYTES_W < 16) ? 16 : BEAT_W + BYTES_W;
  localparam int unsigned SUM_W   = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + 1;

  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic [DATA_W-1:0]   csum_q, csum_d;
  logic                pkt_done_q, pkt_done_d;
  logic [15:0]         last_len_q, last_len_d;
  logic [DATA_W-1:0]   last_csum_q, last_csum_d;
  logic [CNT_W-1:0]    pkt_count_q, pkt_count_d;
  logic [CNT_W-1:0]    byte_count_q, byte_count_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic [2:0]          err_flags_q, err_flags_d;

  logic                done;
  logic                err_orphan, err_sop, err_long;
  logic [BEAT_W-1:0]   fin_beats, next_beats;
  logic [DATA_W-1:0]   fin_csum;
  logic [LEN_W-1:0]    len;
  logic [SUM_W-1:0]    byte_sum;
  logic [CNT_W-1:0]    pkt_base, byte_base, err_base;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] b, input logic inc);
    return (inc && (b != '1)) ? b + CNT_W'(1) : b;
  endfunction

  // Framing FSM plus running beat count / checksum of the open packet.
  always_comb begin
    state_d    = state_q;
    beats_d    = beats_q;
    csum_d     = csum_q;
    done       = 1'b0;
    err_orphan = 1'b0;
    err_sop    = 1'b0;
    err_long   = 1'b0;
    fin_beats  = '0;
    fin_csum   = '0;
    next_beats = beats_q + BEAT_W'(1);
    if (in_valid) begin
      if (in_sop) begin
        // An SOP restarts framing from any state; only inside a packet is it an error.
        err_sop = (state_q == IN_PKT);
        if (in_eop) begin
          done      = 1'b1;
          fin_beats = BEAT_W'(1);
          fin_csum  = in_data;
          state_d   = IDLE;
        end else begin
          beats_d = BEAT_W'(1);
          csum_d  = in_data;
          state_d = IN_PKT;
        end
      end else begin
        case (state_q)
          IN_PKT: begin
            if (next_beats > BEAT_W'(MAX_BEATS)) begin
              err_long = 1'b1;
              state_d  = in_eop ? IDLE : DROP;
            end else if (in_eop) begin
              done      = 1'b1;
              fin_beats = next_beats;
              fin_csum  = csum_q ^ in_data;
              state_d   = IDLE;
            end else begin
              beats_d = next_beats;
              csum_d  = csum_q ^ in_data;
            end
          end
          IDLE: begin
            err_orphan = 1'b1;
            state_d    = in_eop ? IDLE : DROP;
          end
          default: state_d = in_eop ? IDLE : DROP;
        endcase
      end
    end
  end

  // Result and statistics registers; clear replaces the old value with this cycle's event.
  always_comb begin
    len         = LEN_W'(fin_beats) * LEN_W'(BYTES) - LEN_W'(in_empty);
    pkt_base    = clear ? '0 : pkt_count_q;
    byte_base   = clear ? '0 : byte_count_q;
    err_base    = clear ? '0 : err_count_q;
    byte_sum    = SUM_W'(byte_base) + (done ? SUM_W'(len) : '0);
    pkt_done_d  = done;
    last_len_d  = done ? len[15:0] : last_len_q;
    last_csum_d = done ? fin_csum : last_csum_q;
    pkt_count_d = sat_inc(pkt_base, done);
    err_count_d = sat_inc(err_base, err_orphan | err_sop | err_long);
    err_flags_d = (clear ? 3'b000 : err_flags_q) | {err_long, err_sop, err_orphan};
    if (byte_sum > SUM_W'({CNT_W{1'b1}})) byte_count_d = '1;
    else                                  byte_count_d = byte_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      beats_q      <= '0;
      csum_q       <= '0;
      pkt_done_q   <= 1'b0;
      last_len_q   <= '0;
      last_csum_q  <= '0;
      pkt_count_q  <= '0;
      byte_count_q <= '0;
      err_count_q  <= '0;
      err_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      beats_q      <= beats_d;
      csum_q       <= csum_d;
      pkt_done_q   <= pkt_done_d;
      last_len_q   <= last_len_d;
      last_csum_q  <= last_csum_d;
      pkt_count_q  <= pkt_count_d;
      byte_count_q <= byte_count_d;
      err_count_q  <= err_count_d;
      err_flags_q  <= err_flags_d;
    end
  end

  assign pkt_done   = pkt_done_q;
  assign last_len   = last_len_q;
  assign last_csum  = last_csum_q;
  assign pkt_count  = pkt_count_q;
  assign byte_count = byte_count_q;
  assign err_count  = err_count_q;
  assign err_flags  = err_flags_q;

endmodule

// File: tb/tb_avst_rx_monitor.sv
// Directed bench for avst_rx_monitor: a default instance plus a MAX_BEATS=4,
// CNT_W=4 instance sharing the same stream for too-long and saturation cases.
module tb_avst_rx_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic [1:0]  in_empty = '0;
  logic        in_valid = 1'b0;
  logic        clear = 1'b0;

  logic        done0, done1;
  logic [15:0] len0, len1;
  logic [31:0] csum0, csum1;
  logic [31:0] pkt0, byte0, err0;
  logic [3:0]  pkt1, byte1, err1;
  logic [2:0]  flg0, flg1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  avst_rx_monitor u0 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_sop(in_sop),
    .in_eop(in_eop), .in_empty(in_empty), .in_valid(in_valid), .clear(clear),
    .pkt_done(done0), .last_len(len0), .last_csum(csum0), .pkt_count(pkt0),
    .byte_count(byte0), .err_count(err0), .err_flags(flg0)
  );

  avst_rx_monitor #(.MAX_BEATS(4), .CNT_W(4)) u1 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_sop(in_sop),
    .in_eop(in_eop), .in_empty(in_empty), .in_valid(in_valid), .clear(clear),
    .pkt_done(done1), .last_len(len1), .last_csum(csum1), .pkt_count(pkt1),
    .byte_count(byte1), .err_count(err1), .err_flags(flg1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic s, input logic e, input logic [31:0] d,
                      input logic [1:0] emp, input logic clr = 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_sop = s; in_eop = e; in_data = d; in_empty = emp; clear = clr;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();
    check("rst_done", done0, 0);
    check("rst_pkt", pkt0, 0);
    check("rst_len", len0, 0);
    check("rst_flags", flg0, 0);

    // three-beat packet, empty=2 on the eop beat
    send(1, 0, 32'h1111_1111, 0);
    send(0, 0, 32'h2222_2222, 0);
    send(0, 1, 32'h4444_4444, 2);
    idle();
    check("t1_done", done0, 1);
    check("t1_len", len0, 10);
    check("t1_csum", csum0, 32'h7777_7777);
    check("t1_pkt", pkt0, 1);
    check("t1_bytes", byte0, 10);
    idle();
    check("t1_done_pulse", done0, 0);

    // single-beat 1-byte packet
    send(1, 1, 32'h1234_5678, 3);
    idle();
    check("t2_len", len0, 1);
    check("t2_csum", csum0, 32'h1234_5678);
    check("t2_bytes", byte0, 11);
    check("t2_pkt", pkt0, 2);

    // orphan beats, then a normal packet
    send(0, 0, 32'hFFFF_0000, 0);
    idle();
    check("t3_err", err0, 1);
    check("t3_flags", flg0, 3'b001);
    check("t3_nodone", done0, 0);
    send(0, 1, 32'h0000_FFFF, 0);
    idle();
    check("t3_drop_end_done", done0, 0);
    check("t3_drop_end_err", err0, 1);
    send(1, 0, 32'hA5A5_A5A5, 0);
    send(0, 1, 32'h0F0F_0F0F, 0);
    idle();
    check("t3_pkt", pkt0, 3);
    check("t3_len", len0, 8);
    check("t3_csum", csum0, 32'hAAAA_AAAA);
    check("t3_bytes", byte0, 19);

    // sop inside a packet aborts it and restarts
    do_reset();
    send(1, 0, 32'h0000_0001, 0);
    send(0, 0, 32'h0000_0002, 0);
    send(1, 1, 32'hDEAD_BEEF, 0);
    idle();
    check("t4_err", err0, 1);
    check("t4_flags", flg0, 3'b010);
    check("t4_pkt", pkt0, 1);
    check("t4_len", len0, 4);
    check("t4_csum", csum0, 32'hDEAD_BEEF);

    // too-long on u1 (MAX_BEATS=4) with gaps; u0 accepts the same 6-beat packet
    do_reset();
    send(1, 0, 32'h1, 0); idle();
    for (int unsigned i = 0; i < 3; i++) begin
      send(0, 0, 32'h2, 0); idle();
    end
    check("t5_u1_no_err_at_max", err1, 0);
    send(0, 0, 32'h3, 0); idle();
    check("t5_u1_err", err1, 1);
    check("t5_u1_flags", flg1, 3'b100);
    send(0, 1, 32'h4, 0); idle();
    check("t5_u1_nodone", done1, 0);
    check("t5_u1_pkt", pkt1, 0);
    check("t5_u1_err_drop", err1, 1);
    check("t5_u0_done", done0, 1);
    check("t5_u0_len", len0, 24);
    // exactly MAX_BEATS is legal; MAX_BEATS+1 with eop is too long
    send(1, 0, 32'h1, 0); send(0, 0, 32'h2, 0); send(0, 0, 32'h4, 0); send(0, 1, 32'h8, 0);
    idle();
    check("t5_u1_max_pkt", pkt1, 1);
    check("t5_u1_max_len", len1, 16);
    check("t5_u1_max_csum", csum1, 32'hF);
    send(1, 0, 32'h1, 0);
    for (int unsigned i = 0; i < 3; i++) send(0, 0, 32'h2, 0);
    send(0, 1, 32'h3, 0);
    idle();
    check("t5_u1_long_eop_err", err1, 2);
    check("t5_u1_long_eop_pkt", pkt1, 1);
    check("t5_u1_long_eop_done", done1, 0);
    check("t5_u0_pkt", pkt0, 3);

    // saturation of the 4-bit counters
    do_reset();
    for (int unsigned i = 0; i < 16; i++) send(1, 1, i, 0);
    idle();
    check("sat_u1_pkt", pkt1, 4'hF);
    check("sat_u1_bytes", byte1, 4'hF);
    check("sat_u0_pkt", pkt0, 16);
    check("sat_u0_bytes", byte0, 64);

    // clear coincident with a completing eop
    send(1, 0, 32'h0000_00F0, 0);
    send(0, 1, 32'h0000_000F, 1, 1'b1);
    idle();
    check("clr_u0_pkt", pkt0, 1);
    check("clr_u0_bytes", byte0, 7);
    check("clr_u1_pkt", pkt1, 1);
    check("clr_u1_bytes", byte1, 7);
    check("clr_u0_len", len0, 7);
    check("clr_u0_csum", csum0, 32'h0000_00FF);

    // reset mid-packet, then an eop-only beat is an orphan
    send(1, 0, 32'h5555_5555, 0);
    do_reset();
    send(0, 1, 32'h6666_6666, 0);
    idle();
    check("t6_err", err0, 1);
    check("t6_flags", flg0, 3'b001);
    check("t6_nodone", done0, 0);
    check("t6_pkt", pkt0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
